hart_debug_unit: RTL and testbench
==================================

Name: hart_debug_unit

Overview:
- Per-hart Sdext debug controller for the next-gen superscalar commit stage. Supports CW commit slots, external haltreq, single-step, and a resumeack/havereset handshake to the debug module.
- Owns dcsr, dpc, dscratch0 and dscratch1.
- Issues flush and hold requests to the front end, and kill masks to the commit stage.

Parameters:
XLEN, 64, data/PC width
CW, 2, commit slots per cycle; slot 0 is oldest
XDEBUGVER, 4, dcsr.xdebugver field value

Ports:
clk_i  in  1  clock
arst_i  in  1  reset
haltreq_i  in  1  DM halt request, level
resumereq_i  in  1  DM resume request, pulse
ackhavereset_i  in  1  clears havereset_o
dbg_csr_we_i  in  1  DM abstract CSR write
dbg_csr_idx_i  in  12  CSR index for DM write
dbg_csr_wdata_i  in  XLEN  DM write data
commit_valid_i  in  CW  slot wants to commit
commit_pc_i  in  CW*XLEN  slot PCs, slot i at [i*XLEN+:XLEN]
commit_ebreak_i  in  CW  slot is EBREAK
commit_csr_we_i  in  1  slot-0 CSR write; CSR instructions always commit alone in slot 0
commit_csr_idx_i  in  12  slot-0 CSR index
commit_csr_wdata_i  in  XLEN  slot-0 CSR write data
priv_i  in  2  current privilege level
commit_kill_o  out  CW  slot must not retire
halted_o  out  1  hart halted
running_o  out  1  hart running
resumeack_o  out  1  resume completed
havereset_o  out  1  hart was reset, not yet acknowledged
dcsr_o  out  XLEN  dcsr read value
dpc_o  out  XLEN  dpc read value
dscratch0_o  out  XLEN  dscratch0 read value
dscratch1_o  out  XLEN  dscratch1 read value
flush_req_o  out  1  flush pipeline
flush_pc_o  out  XLEN  flush target, always equal to dpc_o
hold_req_o  out  1  stall instruction fetch

Behaviour:
- Reset: arst_i, asynchronous, active-high; clock clk_i.
- Reset values:
  - State RUN.
  - dpc, dscratch0/1 = 0.
  - cause = 0, step = 0, prv = 3.
  - ebreakm/s/u = 0.
  - resumeack_o = 0, havereset_o = 1.
  - All kill, flush and hold outputs = 0.
- Reset mid-operation aborts any halt or step immediately.
- States:
  - RUN.
  - HALTED.
  - RESUMING: waiting for the first commit after resume.
  - STEPPED: one instruction retired under step, halt pending.
- Halt event in RUN: k is the lowest slot with commit_valid_i[k] = 1 and either:
  - commit_ebreak_i[k] with the ebreak enable for priv_i set (ebreaku/ebreaks/ebreakm for priv 0/1/3); or
  - k == 0 and haltreq_i = 1.
- Halt event in STEPPED: slot 0 valid with any request.
- Cause priority within one slot, highest first: ebreak = 1, haltreq = 3, step = 4.
- On a halt event, same cycle:
  - commit_kill_o[j] = 1 for all j >= k.
  - flush_req_o = 1.
- On a halt event, next cycle:
  - dpc = pc[k], cause latched, prv = priv_i.
  - State HALTED.
- An EBREAK whose privilege enable is clear is not a halt event. It commits normally; the exception is handled elsewhere.
- HALTED:
  - hold_req_o = 1, halted_o = 1, commit_kill_o = all 1s.
  - resumereq_i = 1: flush_req_o = 1 (flush_pc_o = dpc), resumeack_o <= 0, state RESUMING.
- RESUMING:
  - First valid slot 0 commits, fixed; this instruction is never re-trapped.
  - If dcsr.step: kill slots 1..CW-1, state STEPPED.
  - Otherwise: state RUN.
  - resumeack_o <= 1 on leaving RESUMING.
  - Exception: an enabled EBREAK in slot 0 halts immediately with cause 1 and is killed.
- STEPPED: the next valid slot-0 instruction is killed and the hart halts with cause 4; dpc = its pc.
- haltreq_i held during RESUMING takes effect once the first commit completes (no livelock).
- running_o = state is RUN, RESUMING or STEPPED.
- CSR writes:
  - Core write applies when commit_valid_i[0] & commit_csr_we_i & !commit_kill_o[0].
  - DM write applies only in HALTED.
  - Core write wins if both occur in the same cycle.
  - Indices: dcsr 0x7B0, dpc 0x7B1, dscratch0 0x7B2, dscratch1 0x7B3.
- dcsr writable fields: ebreakm, ebreaks, ebreaku, step, prv. cause is read-only to both writers.
- dcsr layout:
  - [31:28] xdebugver.
  - [15] ebreakm, [13] ebreaks, [12] ebreaku.
  - [8:6] cause.
  - [2] step, [1:0] prv.
  - All other bits 0.
- havereset_o clears on ackhavereset_i; reset sets it again.

Test Plan:
1. Reset with havereset_o = 1; pulse ackhavereset_i -> havereset_o = 0, running_o = 1, dcsr_o = 0x4000_0003.
2. ebreakm = 1, priv 3, slots {pc 0x100 valid, pc 0x104 ebreak} -> kill = 2'b10, slot 0 retires; next cycle dpc = 0x104, cause = 1, halted_o = 1.
3. haltreq_i with slot 0 pc 0x200 valid -> kill = 2'b11, flush_req_o = 1, dpc = 0x200, cause = 3.
4. Halted, DM writes dcsr step = 1, resumereq_i -> flush_pc_o = dpc; commit 0x200 retires; commit 0x204 killed; dpc = 0x204, cause = 4, resumeack_o = 1.
5. ebreakm = 0, priv 3, ebreak in slot 0 -> no kill, state stays RUN.
6. Assert arst_i while in STEPPED -> state RUN, step = 0, havereset_o = 1.

Source files
------------

// File: rtl/hart_debug_unit.sv
// Per-hart debug controller: halt/resume/single-step sequencing over CW commit
// slots, with ownership of dcsr, dpc, dscratch0 and dscratch1.
module hart_debug_unit #(
    parameter int XLEN      = 64,
    parameter int CW        = 2,
    parameter int XDEBUGVER = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 haltreq_i,
    input  logic                 resumereq_i,
    input  logic                 ackhavereset_i,
    input  logic                 dbg_csr_we_i,
    input  logic [11:0]          dbg_csr_idx_i,
    input  logic [XLEN-1:0]      dbg_csr_wdata_i,
    input  logic [CW-1:0]        commit_valid_i,
    input  logic [CW*XLEN-1:0]   commit_pc_i,
    input  logic [CW-1:0]        commit_ebreak_i,
    input  logic                 commit_csr_we_i,
    input  logic [11:0]          commit_csr_idx_i,
    input  logic [XLEN-1:0]      commit_csr_wdata_i,
    input  logic [1:0]           priv_i,
    output logic [CW-1:0]        commit_kill_o,
    output logic                 halted_o,
    output logic                 running_o,
    output logic                 resumeack_o,
    output logic                 havereset_o,
    output logic [XLEN-1:0]      dcsr_o,
    output logic [XLEN-1:0]      dpc_o,
    output logic [XLEN-1:0]      dscratch0_o,
    output logic [XLEN-1:0]      dscratch1_o,
    output logic                 flush_req_o,
    output logic [XLEN-1:0]      flush_pc_o,
    output logic                 hold_req_o
);

    // state       | meaning
    // ST_RUN      | normal execution, watching for halt events
    // ST_HALTED   | in debug mode, fetch held, all commits killed
    // ST_RESUMING | resumed, waiting for the first slot-0 commit
    // ST_STEPPED  | one instruction retired under step, halt pending
    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED,
        ST_RESUMING,
        ST_STEPPED
    } state_e;

    localparam logic [11:0] IDX_DCSR = 12'h7B0;
    localparam logic [11:0] IDX_DPC  = 12'h7B1;
    localparam logic [11:0] IDX_DS0  = 12'h7B2;
    localparam logic [11:0] IDX_DS1  = 12'h7B3;

    localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
    localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
    localparam logic [2:0] CAUSE_STEP    = 3'd4;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   dpc_q, dpc_d;
    logic [XLEN-1:0]   dscratch0_q, dscratch0_d;
    logic [XLEN-1:0]   dscratch1_q, dscratch1_d;
    logic [2:0]        cause_q, cause_d;
    logic              step_q, step_d;
    logic [1:0]        prv_q, prv_d;
    logic              ebreakm_q, ebreakm_d;
    logic              ebreaks_q, ebreaks_d;
    logic              ebreaku_q, ebreaku_d;
    logic              resumeack_q, resumeack_d;
    logic              havereset_q, havereset_d;

    logic              ebreak_en;
    logic [CW-1:0]     brk_hit;
    logic              halt_evt;
    logic [XLEN-1:0]   halt_pc;
    logic [2:0]        halt_cause;
    logic [CW-1:0]     kill;
    logic              flush;
    logic              hold;

    logic              core_we;
    logic              dm_we;
    logic              csr_we;
    logic [11:0]       csr_idx;
    logic [XLEN-1:0]   csr_wdata;

    always_comb begin
        ebreak_en = 1'b0;
        case (priv_i)
            2'd0:    ebreak_en = ebreaku_q;
            2'd1:    ebreak_en = ebreaks_q;
            2'd3:    ebreak_en = ebreakm_q;
            default: ebreak_en = 1'b0;
        endcase
    end

    assign brk_hit = commit_valid_i & commit_ebreak_i & {CW{ebreak_en}};

    always_comb begin
        state_d     = state_q;
        resumeack_d = resumeack_q;
        halt_evt    = 1'b0;
        halt_pc     = '0;
        halt_cause  = '0;
        kill        = '0;
        flush       = 1'b0;
        hold        = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Descending scan so the oldest qualifying slot wins.
                for (int k = CW - 1; k >= 0; k--) begin
                    if (brk_hit[k] || (k == 0 && commit_valid_i[0] && haltreq_i)) begin
                        halt_evt   = 1'b1;
                        halt_pc    = commit_pc_i[k*XLEN +: XLEN];
                        halt_cause = brk_hit[k] ? CAUSE_EBREAK : CAUSE_HALTREQ;
                        kill       = {CW{1'b1}} << k;
                    end
                end
                if (halt_evt) begin
                    flush   = 1'b1;
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                kill = '1;
                hold = 1'b1;
                if (resumereq_i) begin
                    flush       = 1'b1;
                    resumeack_d = 1'b0;
                    state_d     = ST_RESUMING;
                end
            end
            ST_RESUMING: begin
                kill = {CW{1'b1}} << 1;
                if (commit_valid_i[0]) begin
                    resumeack_d = 1'b1;
                    if (brk_hit[0]) begin
                        halt_evt   = 1'b1;
                        halt_pc    = commit_pc_i[XLEN-1:0];
                        halt_cause = CAUSE_EBREAK;
                        kill       = '1;
                        flush      = 1'b1;
                        state_d    = ST_HALTED;
                    end else if (step_q) begin
                        state_d = ST_STEPPED;
                    end else begin
                        // Haltreq is ignored this cycle so the resumed
                        // instruction always retires; younger ebreaks still trap.
                        kill    = '0;
                        state_d = ST_RUN;
                        for (int k = CW - 1; k >= 1; k--) begin
                            if (brk_hit[k]) begin
                                halt_evt   = 1'b1;
                                halt_pc    = commit_pc_i[k*XLEN +: XLEN];
                                halt_cause = CAUSE_EBREAK;
                                kill       = {CW{1'b1}} << k;
                            end
                        end
                        if (halt_evt) begin
                            flush   = 1'b1;
                            state_d = ST_HALTED;
                        end
                    end
                end
            end
            ST_STEPPED: begin
                kill = '1;
                if (commit_valid_i[0]) begin
                    halt_evt   = 1'b1;
                    halt_pc    = commit_pc_i[XLEN-1:0];
                    halt_cause = brk_hit[0] ? CAUSE_EBREAK :
                                 haltreq_i  ? CAUSE_HALTREQ : CAUSE_STEP;
                    flush      = 1'b1;
                    state_d    = ST_HALTED;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign core_we   = commit_valid_i[0] & commit_csr_we_i & ~kill[0];
    assign dm_we     = dbg_csr_we_i & (state_q == ST_HALTED) & ~core_we;
    assign csr_we    = core_we | dm_we;
    assign csr_idx   = core_we ? commit_csr_idx_i : dbg_csr_idx_i;
    assign csr_wdata = core_we ? commit_csr_wdata_i : dbg_csr_wdata_i;

    always_comb begin
        dpc_d       = dpc_q;
        dscratch0_d = dscratch0_q;
        dscratch1_d = dscratch1_q;
        cause_d     = cause_q;
        step_d      = step_q;
        prv_d       = prv_q;
        ebreakm_d   = ebreakm_q;
        ebreaks_d   = ebreaks_q;
        ebreaku_d   = ebreaku_q;
        havereset_d = havereset_q & ~ackhavereset_i;
        if (csr_we) begin
            case (csr_idx)
                IDX_DCSR: begin
                    ebreakm_d = csr_wdata[15];
                    ebreaks_d = csr_wdata[13];
                    ebreaku_d = csr_wdata[12];
                    step_d    = csr_wdata[2];
                    prv_d     = csr_wdata[1:0];
                end
                IDX_DPC: dpc_d       = csr_wdata;
                IDX_DS0: dscratch0_d = csr_wdata;
                IDX_DS1: dscratch1_d = csr_wdata;
                default: ;
            endcase
        end
        // Halt capture overrides an older slot's write to the same fields.
        if (halt_evt) begin
            dpc_d   = halt_pc;
            cause_d = halt_cause;
            prv_d   = priv_i;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_RUN;
            dpc_q       <= '0;
            dscratch0_q <= '0;
            dscratch1_q <= '0;
            cause_q     <= '0;
            step_q      <= 1'b0;
            prv_q       <= 2'd3;
            ebreakm_q   <= 1'b0;
            ebreaks_q   <= 1'b0;
            ebreaku_q   <= 1'b0;
            resumeack_q <= 1'b0;
            havereset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            dpc_q       <= dpc_d;
            dscratch0_q <= dscratch0_d;
            dscratch1_q <= dscratch1_d;
            cause_q     <= cause_d;
            step_q      <= step_d;
            prv_q       <= prv_d;
            ebreakm_q   <= ebreakm_d;
            ebreaks_q   <= ebreaks_d;
            ebreaku_q   <= ebreaku_d;
            resumeack_q <= resumeack_d;
            havereset_q <= havereset_d;
        end
    end

    always_comb begin
        dcsr_o        = '0;
        dcsr_o[31:28] = 4'(XDEBUGVER);
        dcsr_o[15]    = ebreakm_q;
        dcsr_o[13]    = ebreaks_q;
        dcsr_o[12]    = ebreaku_q;
        dcsr_o[8:6]   = cause_q;
        dcsr_o[2]     = step_q;
        dcsr_o[1:0]   = prv_q;
    end

    assign commit_kill_o = kill;
    assign flush_req_o   = flush;
    assign hold_req_o    = hold;
    assign flush_pc_o    = dpc_q;
    assign dpc_o         = dpc_q;
    assign dscratch0_o   = dscratch0_q;
    assign dscratch1_o   = dscratch1_q;
    assign halted_o      = (state_q == ST_HALTED);
    assign running_o     = (state_q != ST_HALTED);
    assign resumeack_o   = resumeack_q;
    assign havereset_o   = havereset_q;

endmodule

// File: tb/tb_hart_debug_unit.sv
// Directed bench for hart_debug_unit: halt on ebreak/haltreq, single-step,
// CSR write rules and reset abort, with hand-computed expectations.
module tb_hart_debug_unit;

    localparam int XLEN = 64;
    localparam int CW   = 2;

    logic              clk_i = 1'b0;
    logic              arst_i;
    logic              haltreq_i;
    logic              resumereq_i;
    logic              ackhavereset_i;
    logic              dbg_csr_we_i;
    logic [11:0]       dbg_csr_idx_i;
    logic [XLEN-1:0]   dbg_csr_wdata_i;
    logic [CW-1:0]     commit_valid_i;
    logic [CW*XLEN-1:0] commit_pc_i;
    logic [CW-1:0]     commit_ebreak_i;
    logic              commit_csr_we_i;
    logic [11:0]       commit_csr_idx_i;
    logic [XLEN-1:0]   commit_csr_wdata_i;
    logic [1:0]        priv_i;
    logic [CW-1:0]     commit_kill_o;
    logic              halted_o;
    logic              running_o;
    logic              resumeack_o;
    logic              havereset_o;
    logic [XLEN-1:0]   dcsr_o;
    logic [XLEN-1:0]   dpc_o;
    logic [XLEN-1:0]   dscratch0_o;
    logic [XLEN-1:0]   dscratch1_o;
    logic              flush_req_o;
    logic [XLEN-1:0]   flush_pc_o;
    logic              hold_req_o;

    int tests_run = 0;
    int tests_failed = 0;

    hart_debug_unit #(.XLEN(XLEN), .CW(CW), .XDEBUGVER(4)) dut (
        .clk_i              (clk_i),
        .arst_i             (arst_i),
        .haltreq_i          (haltreq_i),
        .resumereq_i        (resumereq_i),
        .ackhavereset_i     (ackhavereset_i),
        .dbg_csr_we_i       (dbg_csr_we_i),
        .dbg_csr_idx_i      (dbg_csr_idx_i),
        .dbg_csr_wdata_i    (dbg_csr_wdata_i),
        .commit_valid_i     (commit_valid_i),
        .commit_pc_i        (commit_pc_i),
        .commit_ebreak_i    (commit_ebreak_i),
        .commit_csr_we_i    (commit_csr_we_i),
        .commit_csr_idx_i   (commit_csr_idx_i),
        .commit_csr_wdata_i (commit_csr_wdata_i),
        .priv_i             (priv_i),
        .commit_kill_o      (commit_kill_o),
        .halted_o           (halted_o),
        .running_o          (running_o),
        .resumeack_o        (resumeack_o),
        .havereset_o        (havereset_o),
        .dcsr_o             (dcsr_o),
        .dpc_o              (dpc_o),
        .dscratch0_o        (dscratch0_o),
        .dscratch1_o        (dscratch1_o),
        .flush_req_o        (flush_req_o),
        .flush_pc_o         (flush_pc_o),
        .hold_req_o         (hold_req_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        haltreq_i          = 1'b0;
        resumereq_i        = 1'b0;
        ackhavereset_i     = 1'b0;
        dbg_csr_we_i       = 1'b0;
        dbg_csr_idx_i      = '0;
        dbg_csr_wdata_i    = '0;
        commit_valid_i     = '0;
        commit_pc_i        = '0;
        commit_ebreak_i    = '0;
        commit_csr_we_i    = 1'b0;
        commit_csr_idx_i   = '0;
        commit_csr_wdata_i = '0;
        priv_i             = 2'd3;
    endtask

    // Advance one clock; inputs return to idle afterwards.
    task automatic tick();
        @(posedge clk_i);
        #1;
        idle();
        #1;
    endtask

    task automatic commit(input logic [1:0] valid, input logic [63:0] pc0,
                          input logic [63:0] pc1, input logic [1:0] ebrk);
        commit_valid_i  = valid;
        commit_pc_i     = {pc1, pc0};
        commit_ebreak_i = ebrk;
        #1;
    endtask

    task automatic dm_write(input logic [11:0] idx, input logic [63:0] data);
        dbg_csr_we_i    = 1'b1;
        dbg_csr_idx_i   = idx;
        dbg_csr_wdata_i = data;
        tick();
    endtask

    initial begin
        idle();
        arst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_havereset", 64'(havereset_o), 64'd1);
        chk("rst_running", 64'(running_o), 64'd1);
        chk("rst_dcsr", dcsr_o, 64'h4000_0003);
        chk("rst_dpc", dpc_o, 64'h0);
        chk("rst_kill_flush_hold", {61'd0, flush_req_o, hold_req_o, resumeack_o}, 64'h0);
        arst_i = 1'b0;
        #2;

        // Test 1: acknowledge havereset
        ackhavereset_i = 1'b1;
        tick();
        chk("ack_havereset", 64'(havereset_o), 64'd0);
        chk("ack_running", 64'(running_o), 64'd1);

        // Core write sets ebreakm plus dscratch0
        commit_csr_we_i    = 1'b1;
        commit_csr_idx_i   = 12'h7B0;
        commit_csr_wdata_i = 64'h8003;
        commit(2'b01, 64'h80, 64'h0, 2'b00);
        chk("csrw_kill", 64'(commit_kill_o), 64'h0);
        tick();
        chk("csrw_dcsr", dcsr_o, 64'h4000_8003);
        commit_csr_we_i    = 1'b1;
        commit_csr_idx_i   = 12'h7B2;
        commit_csr_wdata_i = 64'hCAFE;
        commit(2'b01, 64'h84, 64'h0, 2'b00);
        tick();
        chk("csrw_ds0", dscratch0_o, 64'hCAFE);

        // Test 2: enabled ebreak in slot 1
        commit(2'b11, 64'h100, 64'h104, 2'b10);
        chk("t2_kill", 64'(commit_kill_o), 64'h2);
        chk("t2_flush", 64'(flush_req_o), 64'd1);
        tick();
        chk("t2_dpc", dpc_o, 64'h104);
        chk("t2_dcsr", dcsr_o, 64'h4000_8043);
        chk("t2_halted", 64'(halted_o), 64'd1);
        chk("t2_hold_kill", {61'd0, hold_req_o, commit_kill_o}, 64'h7);

        // Resume without step back to RUN
        resumereq_i = 1'b1;
        #1;
        chk("res_flush", 64'(flush_req_o), 64'd1);
        chk("res_flush_pc", flush_pc_o, 64'h104);
        tick();
        chk("res_running", 64'(running_o), 64'd1);
        chk("res_ack_low", 64'(resumeack_o), 64'd0);
        commit(2'b01, 64'h108, 64'h0, 2'b00);
        chk("res_first_kill", 64'(commit_kill_o), 64'h0);
        tick();
        chk("res_ack", 64'(resumeack_o), 64'd1);

        // Test 3: haltreq on slot 0
        haltreq_i = 1'b1;
        commit(2'b11, 64'h200, 64'h204, 2'b00);
        chk("t3_kill", 64'(commit_kill_o), 64'h3);
        chk("t3_flush", 64'(flush_req_o), 64'd1);
        tick();
        chk("t3_dpc", dpc_o, 64'h200);
        chk("t3_dcsr", dcsr_o, 64'h4000_80C3);

        // Test 4: single step
        dm_write(12'h7B0, 64'h8007);
        chk("t4_dcsr_step", dcsr_o, 64'h4000_80C7);
        resumereq_i = 1'b1;
        #1;
        chk("t4_flush_pc", flush_pc_o, 64'h200);
        tick();
        commit(2'b11, 64'h200, 64'h204, 2'b00);
        chk("t4_step_kill", 64'(commit_kill_o), 64'h2);
        tick();
        chk("t4_resumeack", 64'(resumeack_o), 64'd1);
        chk("t4_stepped_running", 64'(running_o), 64'd1);
        commit(2'b01, 64'h204, 64'h0, 2'b00);
        chk("t4_stepped_kill", 64'(commit_kill_o), 64'h3);
        chk("t4_stepped_flush", 64'(flush_req_o), 64'd1);
        tick();
        chk("t4_dpc", dpc_o, 64'h204);
        chk("t4_dcsr", dcsr_o, 64'h4000_8107);
        chk("t4_halted", 64'(halted_o), 64'd1);

        // Test 5: disabled ebreak does not halt; DM write outside HALTED ignored
        dm_write(12'h7B0, 64'h0003);
        chk("t5_dcsr", dcsr_o, 64'h4000_0103);
        resumereq_i = 1'b1;
        tick();
        commit(2'b01, 64'h300, 64'h0, 2'b00);
        tick();
        commit(2'b01, 64'h304, 64'h0, 2'b01);
        dbg_csr_we_i    = 1'b1;
        dbg_csr_idx_i   = 12'h7B1;
        dbg_csr_wdata_i = 64'hDEAD;
        #1;
        chk("t5_kill", 64'(commit_kill_o), 64'h0);
        chk("t5_flush", 64'(flush_req_o), 64'd0);
        tick();
        chk("t5_halted", 64'(halted_o), 64'd0);
        chk("t5_dpc_unchanged", dpc_o, 64'h204);

        // Test 6: reset while STEPPED
        haltreq_i = 1'b1;
        commit(2'b01, 64'h400, 64'h0, 2'b00);
        tick();
        chk("t6_halted", 64'(halted_o), 64'd1);
        dm_write(12'h7B0, 64'h0007);
        resumereq_i = 1'b1;
        tick();
        commit(2'b01, 64'h400, 64'h0, 2'b00);
        tick();
        chk("t6_pre_dcsr", dcsr_o, 64'h4000_00C7);
        arst_i = 1'b1;
        #2;
        chk("t6_running", 64'(running_o), 64'd1);
        chk("t6_dcsr", dcsr_o, 64'h4000_0003);
        chk("t6_havereset", 64'(havereset_o), 64'd1);
        chk("t6_dpc", dpc_o, 64'h0);
        arst_i = 1'b0;
        commit(2'b01, 64'h500, 64'h0, 2'b00);
        chk("t6_no_kill", 64'(commit_kill_o), 64'h0);
        tick();
        chk("t6_still_run", 64'(halted_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
